pwm_brightness_ctrl: RTL and testbench

PWM_BRIGHTNESS_CTRL -- requirements
Module: pwm_brightness_ctrl

---
 rtl/pwm_brightness_ctrl.sv | 83 ++++++++
 tb/tb_pwm_brightness_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pwm_brightness_ctrl.sv
// pwm_brightness_ctrl: LED brightness PWM with step-up/step-down duty control.
// A free-running PWM_W-bit counter defines the period; duty_req tracks step
// requests and is copied into duty_act once per period so every period runs
// with a single constant duty.
// Optional build macro: PWM_WRAP_EN -- at the exact end points an up step from
// full scale wraps to 0 and a down step from 0 wraps to full scale; all other
// steps still saturate.
module pwm_brightness_ctrl #(
  parameter int unsigned PWM_W = 8,
  parameter int unsigned STEP  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_pulse_n,
  input  logic             down_pulse_n,
  output logic             pwm_out,
  output logic [PWM_W:0]   duty_level,
  output logic             at_max,
  output logic             at_min
);

  localparam int unsigned   SUM_W    = PWM_W + 2;
  localparam logic [SUM_W-1:0] FULL_S = SUM_W'(2 ** PWM_W);
  localparam logic [SUM_W-1:0] STEP_S = SUM_W'(STEP);
  localparam logic [PWM_W:0]   FULL_D = (PWM_W + 1)'(2 ** PWM_W);
  localparam logic [PWM_W:0]   STEP_D = (PWM_W + 1)'(STEP);
  localparam logic [PWM_W-1:0] CNT_LAST = '1;

  logic [PWM_W-1:0] cnt;
  logic [PWM_W:0]   duty_req;
  logic [PWM_W:0]   duty_act;

  logic             step_up;
  logic             step_dn;
  logic [SUM_W-1:0] up_sum;
  logic [PWM_W:0]   up_sat;
  logic [PWM_W:0]   dn_sat;
  logic [PWM_W:0]   duty_nxt;

  // Next requested duty: saturating add/subtract, simultaneous requests cancel
  always_comb begin
    step_up  = ~up_pulse_n & down_pulse_n;
    step_dn  = up_pulse_n & ~down_pulse_n;
    up_sum   = {1'b0, duty_req} + STEP_S;
    up_sat   = (up_sum > FULL_S) ? FULL_D : up_sum[PWM_W:0];
    dn_sat   = (duty_req < STEP_D) ? '0 : (duty_req - STEP_D);
    duty_nxt = duty_req;
    if (step_up) begin
      duty_nxt = up_sat;
`ifdef PWM_WRAP_EN
      if (duty_req == FULL_D) duty_nxt = '0;
`endif
    end else if (step_dn) begin
      duty_nxt = dn_sat;
`ifdef PWM_WRAP_EN
      if (duty_req == '0) duty_nxt = FULL_D;
`endif
    end
  end

  // Period counter, requested duty and once-per-period shadow load
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      duty_req <= '0;
      duty_act <= '0;
    end else begin
      cnt      <= cnt + PWM_W'(1);
      duty_req <= duty_nxt;
      // Loads the pre-step value when a step lands on the same edge
      if (cnt == CNT_LAST) duty_act <= duty_req;
    end
  end

  // Output decode straight from registers
  always_comb begin
    pwm_out    = ({1'b0, cnt} < duty_act);
    duty_level = duty_req;
    at_max     = (duty_req == FULL_D);
    at_min     = (duty_req == '0);
  end

endmodule

// File: tb/tb_pwm_brightness_ctrl.sv
// Directed bench for pwm_brightness_ctrl (PWM_W=8, STEP=32, default build).
module tb_pwm_brightness_ctrl;

  logic       clk;
  logic       rst;
  logic       up_pulse_n;
  logic       down_pulse_n;
  logic       pwm_out;
  logic [8:0] duty_level;
  logic       at_max;
  logic       at_min;

  int total;
  int bad;
  int phase;

  pwm_brightness_ctrl #(.PWM_W(8), .STEP(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .up_pulse_n   (up_pulse_n),
    .down_pulse_n (down_pulse_n),
    .pwm_out      (pwm_out),
    .duty_level   (duty_level),
    .at_max       (at_max),
    .at_min       (at_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; phase is the bench's own expectation of the counter afterwards
  task automatic tick();
    if (rst) phase = 0;
    else     phase = (phase + 1) % 256;
    @(posedge clk);
    #1;
  endtask

  task automatic align();
    while (phase != 0) tick();
  endtask

  // Samples one full period starting at the current cycle
  task automatic measure_period(output int highs, output int first_low);
    highs = 0;
    first_low = -1;
    for (int i = 0; i < 256; i++) begin
      if (pwm_out === 1'b1) highs++;
      else if (first_low < 0) first_low = i;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; up_pulse_n = 1'b0; down_pulse_n = 1'b1;
    repeat (3) tick();
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm: got %0b want 0", pwm_out); end
    total++; if (duty_level !== 9'd0) begin bad++; $display("FAIL reset_duty: got %0d want 0", duty_level); end
    total++; if (at_min !== 1'b1) begin bad++; $display("FAIL reset_at_min: got %0b want 1", at_min); end
    total++; if (at_max !== 1'b0) begin bad++; $display("FAIL reset_at_max: got %0b want 0", at_max); end
    up_pulse_n = 1'b1;
  endtask

  task automatic test_idle();
    int highs;
    int nonmin;
    highs = 0; nonmin = 0;
    rst = 1'b0;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (pwm_out !== 1'b0) highs++;
      if (at_min !== 1'b1 || duty_level !== 9'd0) nonmin++;
    end
    total++; if (highs != 0) begin bad++; $display("FAIL idle_pwm: high cycles %0d want 0", highs); end
    total++; if (nonmin != 0) begin bad++; $display("FAIL idle_level: off-min cycles %0d want 0", nonmin); end
  endtask

  task automatic test_single_up();
    int highs;
    int first_low;
    repeat (10) tick();
    up_pulse_n = 1'b0; tick(); up_pulse_n = 1'b1;
    total++; if (duty_level !== 9'd32) begin bad++; $display("FAIL up1_duty: got %0d want 32", duty_level); end
    total++; if (at_min !== 1'b0) begin bad++; $display("FAIL up1_at_min: got %0b want 0", at_min); end
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL up1_not_yet: got %0b want 0", pwm_out); end
    align();
    measure_period(highs, first_low);
    total++; if (highs != 32) begin bad++; $display("FAIL up1_highs: got %0d want 32", highs); end
    total++; if (first_low != 32) begin bad++; $display("FAIL up1_first_low: got %0d want 32", first_low); end
    measure_period(highs, first_low);
    total++; if (highs != 32) begin bad++; $display("FAIL up1_highs2: got %0d want 32", highs); end
  endtask

  task automatic test_saturate();
    int highs;
    int first_low;
    up_pulse_n = 1'b0; repeat (8) tick(); up_pulse_n = 1'b1;
    total++; if (duty_level !== 9'd256) begin bad++; $display("FAIL sat_duty: got %0d want 256", duty_level); end
    total++; if (at_max !== 1'b1) begin bad++; $display("FAIL sat_at_max: got %0b want 1", at_max); end
    up_pulse_n = 1'b0; tick(); up_pulse_n = 1'b1;
    total++; if (duty_level !== 9'd256) begin bad++; $display("FAIL sat_hold: got %0d want 256", duty_level); end
    align();
    measure_period(highs, first_low);
    total++; if (highs != 256) begin bad++; $display("FAIL sat_highs: got %0d want 256", highs); end
  endtask

  task automatic test_both_low();
    down_pulse_n = 1'b0; repeat (6) tick(); down_pulse_n = 1'b1;
    total++; if (duty_level !== 9'd64) begin bad++; $display("FAIL dn6_duty: got %0d want 64", duty_level); end
    up_pulse_n = 1'b0; down_pulse_n = 1'b0; tick();
    up_pulse_n = 1'b1; down_pulse_n = 1'b1;
    total++; if (duty_level !== 9'd64) begin bad++; $display("FAIL both_duty: got %0d want 64", duty_level); end
    down_pulse_n = 1'b0; tick(); down_pulse_n = 1'b1;
    total++; if (duty_level !== 9'd32) begin bad++; $display("FAIL dn1_duty: got %0d want 32", duty_level); end
    down_pulse_n = 1'b0; repeat (2) tick(); down_pulse_n = 1'b1;
    total++; if (duty_level !== 9'd0) begin bad++; $display("FAIL dn_floor: got %0d want 0", duty_level); end
    total++; if (at_min !== 1'b1) begin bad++; $display("FAIL dn_at_min: got %0b want 1", at_min); end
  endtask

  task automatic test_shadow_miss();
    int highs;
    int first_low;
    up_pulse_n = 1'b0; repeat (2) tick(); up_pulse_n = 1'b1;
    align();
    while (phase != 255) tick();
    up_pulse_n = 1'b0; tick(); up_pulse_n = 1'b1;
    total++; if (duty_level !== 9'd96) begin bad++; $display("FAIL miss_duty: got %0d want 96", duty_level); end
    measure_period(highs, first_low);
    total++; if (highs != 64) begin bad++; $display("FAIL miss_old_period: got %0d want 64", highs); end
    measure_period(highs, first_low);
    total++; if (highs != 96) begin bad++; $display("FAIL miss_new_period: got %0d want 96", highs); end
  endtask

  task automatic test_mid_reset();
    int highs;
    int first_low;
    up_pulse_n = 1'b0; tick(); up_pulse_n = 1'b1;
    align();
    repeat (100) tick();
    total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL mid_pre_pwm: got %0b want 1", pwm_out); end
    rst = 1'b1; tick();
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL mid_rst_pwm: got %0b want 0", pwm_out); end
    total++; if (duty_level !== 9'd0) begin bad++; $display("FAIL mid_rst_duty: got %0d want 0", duty_level); end
    total++; if (at_min !== 1'b1) begin bad++; $display("FAIL mid_rst_at_min: got %0b want 1", at_min); end
    rst = 1'b0; up_pulse_n = 1'b0; tick(); up_pulse_n = 1'b1;
    total++; if (duty_level !== 9'd32) begin bad++; $display("FAIL rel_step: got %0d want 32", duty_level); end
    highs = 0;
    while (phase != 0) begin
      if (pwm_out !== 1'b0) highs++;
      tick();
    end
    total++; if (highs != 0) begin bad++; $display("FAIL rel_partial: got %0d want 0", highs); end
    measure_period(highs, first_low);
    total++; if (highs != 32) begin bad++; $display("FAIL rel_period: got %0d want 32", highs); end
  endtask

  initial begin
    total = 0; bad = 0; phase = 0;
    rst = 1'b1; up_pulse_n = 1'b1; down_pulse_n = 1'b1;
    test_reset();
    test_idle();
    test_single_up();
    test_saturate();
    test_both_low();
    test_shadow_miss();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
